// File: rtl/btn_draw_sched_if.sv
// LCD-side channels of the button draw scheduler.
//   window command : lcd_win_valid/lcd_win_ready carrying lcd_xstart..lcd_yend
//   pixel stream   : lcd_pix_valid/lcd_pix_ready carrying lcd_pix_data (RGB565)
// master = scheduler (drives valid/data), slave = LCD pixel writer (drives ready).
interface btn_draw_sched_if;
  logic        lcd_win_valid;
  logic        lcd_win_ready;
  logic [15:0] lcd_xstart;
  logic [15:0] lcd_xend;
  logic [15:0] lcd_ystart;
  logic [15:0] lcd_yend;
  logic        lcd_pix_valid;
  logic        lcd_pix_ready;
  logic [15:0] lcd_pix_data;

  modport master (
    output lcd_win_valid, lcd_xstart, lcd_xend, lcd_ystart, lcd_yend,
    input  lcd_win_ready,
    output lcd_pix_valid, lcd_pix_data,
    input  lcd_pix_ready
  );

  modport slave (
    input  lcd_win_valid, lcd_xstart, lcd_xend, lcd_ystart, lcd_yend,
    output lcd_win_ready,
    input  lcd_pix_valid, lcd_pix_data,
    output lcd_pix_ready
  );
endinterface

// File: rtl/btn_draw_sched.sv
// Round-robin draw scheduler for the touch-button blocks. Grants one button
// that raises update, runs its draw/cnext/drawdone handshake, and forwards
// its window and colour stream to the LCD pixel writer.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   enable              allows new grants; a draw in progress always completes
//   btn_update          per-button redraw request (level)
//   btn_draw            one-hot draw strobe, high for the whole draw
//   btn_cnext           one-hot single-cycle advance-pixel pulse
//   btn_drawdone        per-button draw-complete flag
//   btn_x/ystart/end    per-button window, button i at [16i+15:16i]
//   btn_color           per-button RGB565 colour
//   lcd                 window command and pixel channels (master side)
//   busy                scheduler not idle
//   grant_id            current/last granted button
//   err                 sticky pixel-count / drawdone mismatch
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an enabled request
// GRANT | draw raised; button drops drawdone and clears update
// WIN   | window command offered to the LCD
// PIX   | current colour offered to the LCD
// CNX   | cnext pulse to the button after a pixel was accepted
// WAIT  | settle time for the button's position/bitmap pipeline
// DONE  | draw held until the button reports drawdone
module btn_draw_sched #(
  parameter int NBTN   = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NBTN-1:0]    btn_update,
  output logic [NBTN-1:0]    btn_draw,
  output logic [NBTN-1:0]    btn_cnext,
  input  logic [NBTN-1:0]    btn_drawdone,
  input  logic [16*NBTN-1:0] btn_xstart,
  input  logic [16*NBTN-1:0] btn_xend,
  input  logic [16*NBTN-1:0] btn_ystart,
  input  logic [16*NBTN-1:0] btn_yend,
  input  logic [16*NBTN-1:0] btn_color,
  btn_draw_sched_if.master   lcd,
  output logic               busy,
  output logic [3:0]         grant_id,
  output logic               err
);

  localparam int SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int DONE_WAIT   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WIN, S_PIX, S_CNX, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Per-button fields padded to 16 entries so the 4-bit grant index
  // selects them directly.
  logic [15:0] xs_a  [16];
  logic [15:0] xe_a  [16];
  logic [15:0] ys_a  [16];
  logic [15:0] ye_a  [16];
  logic [15:0] col_a [16];
  logic [15:0] dd_pad;
  logic [15:0] oh_pad;
  logic        dd_g;

  logic        arb_found;
  logic [3:0]  arb_idx;
  int          arb_d;
  int          arb_best;
  logic        grant_go;

  logic [31:0] win_w, win_h, area;
  logic [31:0] cnt;
  logic [15:0] settle_cnt;
  logic [2:0]  done_cnt;

  logic        draw_on, cnext_on, win_valid, pix_valid, abort;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      xs_a[i]  = '0;
      xe_a[i]  = '0;
      ys_a[i]  = '0;
      ye_a[i]  = '0;
      col_a[i] = '0;
    end
    for (int i = 0; i < NBTN; i++) begin
      xs_a[i]  = btn_xstart[16*i +: 16];
      xe_a[i]  = btn_xend[16*i +: 16];
      ys_a[i]  = btn_ystart[16*i +: 16];
      ye_a[i]  = btn_yend[16*i +: 16];
      col_a[i] = btn_color[16*i +: 16];
    end
  end

  assign dd_pad = 16'(btn_drawdone);
  assign oh_pad = 16'd1 << grant_id;
  assign dd_g   = dd_pad[grant_id];

  // Round-robin: the requester at the smallest cyclic distance above
  // grant_id wins; distance 0 is the button right after the last grant.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = grant_id;
    arb_best  = NBTN;
    arb_d     = 0;
    for (int i = 0; i < NBTN; i++) begin
      arb_d = i - int'(grant_id) - 1;
      if (arb_d < 0) arb_d = arb_d + NBTN;
      if (btn_update[i] && arb_d < arb_best) begin
        arb_best  = arb_d;
        arb_idx   = 4'(i);
        arb_found = 1'b1;
      end
    end
  end

  assign grant_go = enable && arb_found;

  assign win_w = 32'(xe_a[arb_idx]) - 32'(xs_a[arb_idx]) + 32'd1;
  assign win_h = 32'(ye_a[arb_idx]) - 32'(ys_a[arb_idx]) + 32'd1;
  assign area  = win_w * win_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      grant_id       <= 4'(NBTN - 1);
      lcd.lcd_xstart <= '0;
      lcd.lcd_xend   <= '0;
      lcd.lcd_ystart <= '0;
      lcd.lcd_yend   <= '0;
      cnt            <= '0;
      settle_cnt     <= '0;
      done_cnt       <= '0;
      err            <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_go) begin
        grant_id       <= arb_idx;
        lcd.lcd_xstart <= xs_a[arb_idx];
        lcd.lcd_xend   <= xe_a[arb_idx];
        lcd.lcd_ystart <= ys_a[arb_idx];
        lcd.lcd_yend   <= ye_a[arb_idx];
        cnt            <= area;
      end else if (state == S_PIX && lcd.lcd_pix_ready && !abort) begin
        cnt <= cnt - 32'd1;
      end

      if (state == S_CNX)
        settle_cnt <= 16'(SETTLE_LOAD);
      else if (state == S_WAIT && settle_cnt != '0)
        settle_cnt <= settle_cnt - 16'd1;

      // Counts down the cycles spent in DONE without drawdone; once it
      // reaches zero every further waiting cycle flags the overrun.
      if (state != S_DONE)
        done_cnt <= 3'(DONE_WAIT);
      else if (!dd_g && done_cnt != '0)
        done_cnt <= done_cnt - 3'd1;

      if (abort || (state == S_DONE && !dd_g && done_cnt == '0))
        err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    draw_on   = 1'b1;
    cnext_on  = 1'b0;
    win_valid = 1'b0;
    pix_valid = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        draw_on = 1'b0;
        if (grant_go) state_nxt = S_GRANT;
      end
      S_GRANT: state_nxt = S_WIN;
      S_WIN: begin
        win_valid = 1'b1;
        if (dd_g && cnt != '0) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end else if (lcd.lcd_win_ready) begin
          state_nxt = S_PIX;
        end
      end
      S_PIX: begin
        pix_valid = 1'b1;
        if (dd_g && cnt != '0) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end else if (lcd.lcd_pix_ready) begin
          state_nxt = S_CNX;
        end
      end
      S_CNX: begin
        cnext_on = 1'b1;
        if (dd_g && cnt != '0) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end else if (SETTLE == 0) begin
          state_nxt = (cnt == '0) ? S_DONE : S_PIX;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dd_g && cnt != '0) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end else if (settle_cnt == '0) begin
          state_nxt = (cnt == '0) ? S_DONE : S_PIX;
        end
      end
      S_DONE: begin
        if (dd_g) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign btn_draw          = draw_on  ? oh_pad[NBTN-1:0] : '0;
  assign btn_cnext         = cnext_on ? oh_pad[NBTN-1:0] : '0;
  assign lcd.lcd_win_valid = win_valid;
  assign lcd.lcd_pix_valid = pix_valid;
  assign lcd.lcd_pix_data  = col_a[grant_id];
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_btn_draw_sched.sv
module tb_btn_draw_sched;
  localparam int NBTN   = 4;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [NBTN-1:0]    btn_update, btn_draw, btn_cnext, btn_drawdone;
  logic [16*NBTN-1:0] btn_xstart, btn_xend, btn_ystart, btn_yend, btn_color;
  logic               busy, err;
  logic [3:0]         grant_id;

  btn_draw_sched_if lcd_bus();

  btn_draw_sched #(.NBTN(NBTN), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .btn_update(btn_update), .btn_draw(btn_draw), .btn_cnext(btn_cnext),
    .btn_drawdone(btn_drawdone),
    .btn_xstart(btn_xstart), .btn_xend(btn_xend),
    .btn_ystart(btn_ystart), .btn_yend(btn_yend), .btn_color(btn_color),
    .lcd(lcd_bus), .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-owned button configuration
  logic [15:0] win_xs [NBTN];
  logic [15:0] win_xe [NBTN];
  logic [15:0] win_ys [NBTN];
  logic [15:0] win_ye [NBTN];
  int          abort_after [NBTN];
  bit          hold_done [NBTN];
  bit          force_done [NBTN];
  int          req_cnt [NBTN];
  bit          ready_low = 1'b0;
  logic [15:0] col_seed;

  // Button model state
  int              served [NBTN];
  logic [15:0]     posx [NBTN];
  logic [15:0]     posy [NBTN];
  int              pixn [NBTN];
  logic [NBTN-1:0] done_m;
  logic [NBTN-1:0] draw_q;

  typedef struct {
    int          id;
    logic [15:0] xs, xe, ys, ye;
  } win_t;
  win_t        exp_win[$];
  logic [15:0] exp_pix[$];
  int          ref_last;

  function automatic logic [15:0] colf(int b, logic [15:0] x, logic [15:0] y);
    return {4'(b), x[5:0], y[5:0]} ^ col_seed;
  endfunction

  function automatic int area_of(int b);
    return (int'(win_xe[b]) - int'(win_xs[b]) + 1) * (int'(win_ye[b]) - int'(win_ys[b]) + 1);
  endfunction

  always_comb begin
    btn_update   = '0;
    btn_drawdone = '0;
    btn_xstart   = '0;
    btn_xend     = '0;
    btn_ystart   = '0;
    btn_yend     = '0;
    btn_color    = '0;
    for (int i = 0; i < NBTN; i++) begin
      btn_update[i]          = (req_cnt[i] != served[i]);
      btn_drawdone[i]        = done_m[i] | force_done[i];
      btn_xstart[16*i +: 16] = win_xs[i];
      btn_xend[16*i +: 16]   = win_xe[i];
      btn_ystart[16*i +: 16] = win_ys[i];
      btn_yend[16*i +: 16]   = win_ye[i];
      btn_color[16*i +: 16]  = colf(i, posx[i], posy[i]);
    end
  end

  // Button model: raster position walks the window on each cnext,
  // drawdone rises after the last (or the abort_after-th) pixel.
  always @(posedge clk) begin
    for (int i = 0; i < NBTN; i++) begin
      if (rst) begin
        done_m[i] <= 1'b1;
        draw_q[i] <= 1'b0;
        posx[i]   <= '0;
        posy[i]   <= '0;
        pixn[i]   <= 0;
      end else begin
        draw_q[i] <= btn_draw[i];
        if (btn_draw[i] && !draw_q[i]) begin
          done_m[i] <= 1'b0;
          served[i] <= req_cnt[i];
          posx[i]   <= win_xs[i];
          posy[i]   <= win_ys[i];
          pixn[i]   <= 0;
        end else if (btn_cnext[i]) begin
          pixn[i] <= pixn[i] + 1;
          if (posx[i] == win_xe[i]) begin
            posx[i] <= win_xs[i];
            posy[i] <= posy[i] + 16'd1;
          end else begin
            posx[i] <= posx[i] + 16'd1;
          end
          if ((abort_after[i] != 0 && pixn[i] + 1 == abort_after[i]) ||
              (!hold_done[i] && pixn[i] + 1 == area_of(i)))
            done_m[i] <= 1'b1;
        end
      end
    end
  end

  // Random LCD backpressure, changed just after each active edge
  always @(posedge clk) begin
    #1;
    lcd_bus.lcd_win_ready = ($urandom_range(0, 3) != 0);
    lcd_bus.lcd_pix_ready = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  int          cyc = 0;
  int          last_cnx = -100;
  logic        pv_q = 1'b0, pr_q = 1'b0, wv_q = 1'b0, wr_q = 1'b0, hs_q = 1'b0;
  logic [15:0] pd_q = '0, wx_q = '0;
  logic [3:0]  gid_q = '0;

  always @(negedge clk) begin
    logic [NBTN-1:0] oh;
    win_t w;
    logic [15:0] p;
    if (rst) begin
      pv_q = 1'b0; wv_q = 1'b0; hs_q = 1'b0; last_cnx = -100;
    end else begin
      cyc++;
      if (pv_q && !pr_q) begin
        checks++;
        if (!(lcd_bus.lcd_pix_valid && lcd_bus.lcd_pix_data == pd_q)) begin
          errors++;
          $display("FAIL pix_hold got valid=%0b data=%h want valid=1 data=%h",
                   lcd_bus.lcd_pix_valid, lcd_bus.lcd_pix_data, pd_q);
        end
      end
      if (wv_q && !wr_q) begin
        checks++;
        if (!(lcd_bus.lcd_win_valid && lcd_bus.lcd_xstart == wx_q)) begin
          errors++;
          $display("FAIL win_hold got valid=%0b xs=%h want valid=1 xs=%h",
                   lcd_bus.lcd_win_valid, lcd_bus.lcd_xstart, wx_q);
        end
      end
      if (lcd_bus.lcd_win_valid && lcd_bus.lcd_win_ready) begin
        checks++;
        if (exp_win.size() == 0) begin
          errors++;
          $display("FAIL win_unexpected got id=%0d want no window", grant_id);
        end else begin
          w = exp_win.pop_front();
          if (int'(grant_id) != w.id ||
              {lcd_bus.lcd_xstart, lcd_bus.lcd_xend, lcd_bus.lcd_ystart, lcd_bus.lcd_yend}
              != {w.xs, w.xe, w.ys, w.ye}) begin
            errors++;
            $display("FAIL win_cmd got id=%0d win=%h/%h/%h/%h want id=%0d win=%h/%h/%h/%h",
                     grant_id, lcd_bus.lcd_xstart, lcd_bus.lcd_xend, lcd_bus.lcd_ystart,
                     lcd_bus.lcd_yend, w.id, w.xs, w.xe, w.ys, w.ye);
          end
        end
      end
      if (lcd_bus.lcd_pix_valid && lcd_bus.lcd_pix_ready) begin
        checks++;
        if (exp_pix.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected got %h want no pixel", lcd_bus.lcd_pix_data);
        end else begin
          p = exp_pix.pop_front();
          if (lcd_bus.lcd_pix_data !== p) begin
            errors++;
            $display("FAIL pix_data got %h want %h", lcd_bus.lcd_pix_data, p);
          end
        end
      end
      oh = NBTN'(1) << gid_q;
      if (btn_cnext != '0) begin
        checks++;
        if (!(hs_q && btn_cnext == oh && cyc - last_cnx >= 2 + SETTLE)) begin
          errors++;
          $display("FAIL cnext got %b gap=%0d after_hs=%0b want %b gap>=%0d after_hs=1",
                   btn_cnext, cyc - last_cnx, hs_q, oh, 2 + SETTLE);
        end
        last_cnx = cyc;
      end else if (hs_q) begin
        checks++;
        errors++;
        $display("FAIL cnext_missing got %b want %b", btn_cnext, oh);
      end
      oh = busy ? (NBTN'(1) << grant_id) : '0;
      checks++;
      if (btn_draw !== oh) begin
        errors++;
        $display("FAIL draw got %b want %b", btn_draw, oh);
      end
      pv_q  = lcd_bus.lcd_pix_valid;
      pr_q  = lcd_bus.lcd_pix_ready;
      pd_q  = lcd_bus.lcd_pix_data;
      wv_q  = lcd_bus.lcd_win_valid;
      wr_q  = lcd_bus.lcd_win_ready;
      wx_q  = lcd_bus.lcd_xstart;
      hs_q  = lcd_bus.lcd_pix_valid && lcd_bus.lcd_pix_ready;
      gid_q = grant_id;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rr_next(int last, logic [NBTN-1:0] m);
    for (int k = 1; k <= NBTN; k++) begin
      int idx;
      idx = (last + k) % NBTN;
      if (((m >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic expect_draw(int b);
    win_t w;
    int n, k;
    w.id = b; w.xs = win_xs[b]; w.xe = win_xe[b]; w.ys = win_ys[b]; w.ye = win_ye[b];
    exp_win.push_back(w);
    n = (abort_after[b] != 0) ? abort_after[b] : area_of(b);
    k = 0;
    for (int y = int'(win_ys[b]); y <= int'(win_ye[b]); y++)
      for (int x = int'(win_xs[b]); x <= int'(win_xe[b]); x++) begin
        if (k < n) exp_pix.push_back(colf(b, 16'(x), 16'(y)));
        k++;
      end
  endtask

  task automatic schedule_exp(logic [NBTN-1:0] m);
    logic [NBTN-1:0] pend;
    int b;
    pend = m;
    while (pend != '0) begin
      b = rr_next(ref_last, pend);
      expect_draw(b);
      pend &= ~(NBTN'(1) << b);
      ref_last = b;
    end
  endtask

  task automatic raise(logic [NBTN-1:0] m);
    for (int i = 0; i < NBTN; i++)
      if (m[i]) req_cnt[i]++;
  endtask

  task automatic wait_idle(string name);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_win.size() == 0 && exp_pix.size() == 0 && btn_update == '0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout got win_left=%0d pix_left=%0d busy=%0b want all drained and idle",
             name, exp_win.size(), exp_pix.size(), busy);
  endtask

  task automatic set_win(int b, int xs, int w, int ys, int h);
    win_xs[b] = 16'(xs); win_xe[b] = 16'(xs + w - 1);
    win_ys[b] = 16'(ys); win_ye[b] = 16'(ys + h - 1);
  endtask

  task automatic check_reset();
    check("rst_draw",  64'(btn_draw), 64'(0));
    check("rst_cnext", 64'(btn_cnext), 64'(0));
    check("rst_valid", 64'({lcd_bus.lcd_win_valid, lcd_bus.lcd_pix_valid}), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_err",   64'(err), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(NBTN - 1));
    check("rst_win",   {lcd_bus.lcd_xstart, lcd_bus.lcd_xend, lcd_bus.lcd_ystart, lcd_bus.lcd_yend}, 64'(0));
  endtask

  initial begin
    int s;
    bit seen;
    col_seed = 16'($urandom);
    for (int i = 0; i < NBTN; i++) begin
      set_win(i, 0, 1, 0, 1);
      abort_after[i] = 0; hold_done[i] = 1'b0; force_done[i] = 1'b0;
    end
    enable = 1'b1;
    rst = 1'b1;
    ref_last = NBTN - 1;
    tick(3);
    check_reset();
    rst = 1'b0;

    // Single button, 2x2 window
    set_win(1, 10, 2, 20, 2);
    schedule_exp(4'b0010);
    raise(4'b0010);
    wait_idle("single");
    check("single_err", 64'(err), 64'(0));

    // Simultaneous 0,2,3 from reset, 0 re-requests during 2's draw
    rst = 1'b1; tick(2); rst = 1'b0; ref_last = NBTN - 1;
    set_win(0, 100, 2, 5, 1);
    set_win(2, 200, 1, 7, 2);
    set_win(3, 300, 3, 9, 1);
    schedule_exp(4'b1101);
    expect_draw(0);
    ref_last = 0;
    raise(4'b1101);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = btn_draw[2];
    end
    check("rr_draw2_seen", 64'(seen), 64'(1));
    raise(4'b0001);
    wait_idle("rr");

    // LCD stall mid-stream
    set_win(1, 0, 3, 5, 3);
    schedule_exp(4'b0010);
    raise(4'b0010);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = (exp_pix.size() <= 5);
    end
    check("stall_reached", 64'(seen), 64'(1));
    ready_low = 1'b1;
    tick(1);
    s = exp_pix.size();
    tick(10);
    check("stall_no_pix", 64'(exp_pix.size()), 64'(s));
    check("stall_valid", 64'(lcd_bus.lcd_pix_valid), 64'(1));
    ready_low = 1'b0;
    wait_idle("stall");

    // Enable gating
    enable = 1'b0;
    set_win(3, 40, 2, 41, 2);
    schedule_exp(4'b1000);
    raise(4'b1000);
    tick(10);
    check("en_off_busy", 64'(busy), 64'(0));
    check("en_off_draw", 64'(btn_draw), 64'(0));
    enable = 1'b1;
    tick(1);
    check("en_on_grant", 64'(busy), 64'(1));
    tick(3);
    enable = 1'b0;
    wait_idle("en_mid");
    enable = 1'b1;
    check("en_err", 64'(err), 64'(0));

    // Randomised rounds
    for (int r = 0; r < 6; r++) begin
      logic [NBTN-1:0] m;
      for (int b = 0; b < NBTN; b++)
        set_win(b, $urandom_range(0, 1000), $urandom_range(1, 3),
                $urandom_range(0, 1000), $urandom_range(1, 3));
      m = NBTN'($urandom_range(1, (1 << NBTN) - 1));
      schedule_exp(m);
      raise(m);
      wait_idle("rand");
    end
    check("rand_err", 64'(err), 64'(0));

    // Early drawdone aborts the draw
    set_win(2, 50, 2, 60, 2);
    abort_after[2] = 2;
    schedule_exp(4'b0100);
    raise(4'b0100);
    wait_idle("abort");
    check("abort_err", 64'(err), 64'(1));
    abort_after[2] = 0;
    set_win(0, 70, 2, 80, 1);
    schedule_exp(4'b0001);
    raise(4'b0001);
    wait_idle("after_abort");
    check("abort_sticky", 64'(err), 64'(1));

    // Reset during PIX with requests pending on 0 and 2
    set_win(1, 0, 3, 0, 3);
    schedule_exp(4'b0010);
    raise(4'b0010);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = lcd_bus.lcd_pix_valid;
    end
    check("rst_pix_seen", 64'(seen), 64'(1));
    raise(4'b0101);
    rst = 1'b1;
    tick(1);
    check_reset();
    exp_win.delete();
    exp_pix.delete();
    ref_last = NBTN - 1;
    schedule_exp(4'b0101);
    tick(1);
    rst = 1'b0;
    wait_idle("post_rst");
    check("post_rst_err", 64'(err), 64'(0));

    // drawdone late in DONE: err set, draw keeps waiting
    hold_done[3] = 1'b1;
    set_win(3, 9, 2, 9, 1);
    schedule_exp(4'b1000);
    raise(4'b1000);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = (exp_pix.size() == 0 && exp_win.size() == 0);
    end
    check("late_pix_done", 64'(seen), 64'(1));
    tick(20);
    check("late_err", 64'(err), 64'(1));
    check("late_busy", 64'(busy), 64'(1));
    force_done[3] = 1'b1;
    wait_idle("late");
    check("late_idle", 64'(busy), 64'(0));
    force_done[3] = 1'b0;
    hold_done[3] = 1'b0;

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
